// File: rtl/dct_block_assembler.sv
// dct_block_assembler: raster pixel stream -> 8x8 blocks for the DCT core.
// Buffers one 8-row strip in flops. It then emits IMG_WIDTH/8 blocks per strip,
// left to right, as 512-bit words (byte i = row i>>3, column i&7).
// Optional build macro DCT_BLKASM_PINGPONG_EN adds a second strip buffer, so
// the writer can fill one strip while the reader drains the other.
module dct_block_assembler #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   pix_data,
  input  logic         pix_valid,
  input  logic         pix_sof,
  output logic         pix_ready,
  output logic [511:0] block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_last,
  output logic         frame_done
);

`ifdef DCT_BLKASM_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif
  localparam int NB = IMG_WIDTH / 8;
  localparam int NS = IMG_HEIGHT / 8;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  // Row index into the flat buffer array: {buffer select, row} when ping-pong
  localparam int RW = (NBUF == 2) ? 4 : 3;
  localparam logic PP = (NBUF == 2);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [BW-1:0] BLK_LAST   = BW'(NB - 1);
  localparam logic [SW-1:0] STRIP_LAST = SW'(NS - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  logic [7:0]    mem [NBUF*8][IMG_WIDTH];
  logic [CW-1:0] wr_col;
  logic [2:0]    wr_row;
  logic          wr_sel, rd_sel;
  logic [1:0]    full;
  logic [SW-1:0] wr_strip;
  logic [SW-1:0] tag [2];
  state_t        state;
  logic [BW-1:0] blk_idx;

  logic          wr_en, hs, wr_done, last_blk, strip_end;
  logic [2:0]    eff_row;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] wr_ridx;
  logic          rd_alt, pend_cur, pend_alt;
  logic          load_en, load_sel, rd_sel_n, wr_sel_n, pix_ready_n, last_n;
  logic [BW-1:0] load_idx;
  logic [SW-1:0] load_tag;
  logic [1:0]    full_n;
  state_t        state_n;
  logic [511:0]  blk_n;

  // Handshakes and write position; an SOF pixel always lands at (0,0)
  always_comb begin
    wr_en     = pix_valid && pix_ready;
    hs        = (state == EMIT) && block_ready;
    eff_row   = pix_sof ? 3'd0 : wr_row;
    eff_col   = pix_sof ? '0 : wr_col;
    wr_ridx   = RW'({wr_sel, eff_row});
    wr_done   = wr_en && !pix_sof && (wr_row == 3'd7) && (wr_col == COL_LAST);
    last_blk  = (blk_idx == BLK_LAST);
    strip_end = hs && last_blk;
    rd_alt    = rd_sel ^ PP;
    // A strip completing this very cycle counts as pending; its last pixel
    // is forwarded into the block gather below.
    pend_cur  = full[rd_sel] || (wr_done && (wr_sel == rd_sel));
    pend_alt  = (PP && full[rd_alt]) || (wr_done && (wr_sel == rd_alt));
  end

  // Reader next state: which buffer/block gets loaded into block_out
  always_comb begin
    state_n  = state;
    rd_sel_n = rd_sel;
    load_en  = 1'b0;
    load_sel = rd_sel;
    load_idx = '0;
    case (state)
      IDLE: begin
        if (pend_cur) begin
          load_en = 1'b1;
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (hs) begin
          if (!last_blk) begin
            load_en  = 1'b1;
            load_idx = BW'(blk_idx + 1'b1);
          end else begin
            rd_sel_n = rd_alt;
            if (pend_alt) begin
              load_en  = 1'b1;
              load_sel = rd_alt;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Buffer occupancy and the registered pix_ready it implies
  always_comb begin
    full_n = full;
    if (strip_end) full_n[rd_sel] = 1'b0;
    if (wr_done)   full_n[wr_sel] = 1'b1;
    wr_sel_n    = wr_done ? (wr_sel ^ PP) : wr_sel;
    pix_ready_n = !full_n[wr_sel_n];
    load_tag    = (wr_done && (wr_sel == load_sel)) ? wr_strip : tag[load_sel];
    last_n      = (load_idx == BLK_LAST) && (load_tag == STRIP_LAST);
  end

  // Block gather: 64 bytes of the selected block, with same-cycle write bypass
  for (genvar i = 0; i < 64; i++) begin : g_byte
    logic [CW-1:0] col;
    logic [RW-1:0] ridx;
    assign col  = CW'(int'(load_idx) * 8 + (i % 8));
    assign ridx = RW'({load_sel, 3'(i / 8)});
    assign blk_n[i*8 +: 8] = (wr_en && (wr_ridx == ridx) && (eff_col == col))
                             ? pix_data : mem[ridx][col];
  end

  // Strip storage; contents need no reset since pending flags gate all reads
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ridx][eff_col] <= pix_data;
  end

  // Writer position, strip numbering within the frame, and buffer flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_col    <= '0;
      wr_row    <= '0;
      wr_sel    <= 1'b0;
      wr_strip  <= '0;
      tag[0]    <= '0;
      tag[1]    <= '0;
      full      <= '0;
      pix_ready <= 1'b0;
    end else begin
      full      <= full_n;
      wr_sel    <= wr_sel_n;
      pix_ready <= pix_ready_n;
      if (wr_en) begin
        if (pix_sof) begin
          wr_row   <= 3'd0;
          wr_col   <= CW'(1);
          wr_strip <= '0;
        end else begin
          if (wr_col == COL_LAST) begin
            wr_col <= '0;
            wr_row <= wr_row + 3'd1;
          end else begin
            wr_col <= wr_col + 1'b1;
          end
          if (wr_done) begin
            tag[wr_sel] <= wr_strip;
            wr_strip    <= (wr_strip == STRIP_LAST) ? '0 : SW'(wr_strip + 1'b1);
          end
        end
      end
    end
  end

  // Reader FSM with registered block outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_sel      <= 1'b0;
      blk_idx     <= '0;
      block_out   <= '0;
      block_valid <= 1'b0;
      block_last  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      rd_sel      <= rd_sel_n;
      block_valid <= (state_n == EMIT);
      frame_done  <= strip_end && block_last;
      if (load_en) begin
        block_out  <= blk_n;
        block_last <= last_n;
        blk_idx    <= load_idx;
      end else if (state_n == IDLE) begin
        block_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct_block_assembler.sv
// Scoreboard bench for dct_block_assembler (16x16 frame, 2 blocks per strip).
module tb_dct_block_assembler;
  localparam int W  = 16;
  localparam int H  = 16;
  localparam int NB = W / 8;
  localparam int NS = H / 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   pix_data;
  logic         pix_valid, pix_sof, pix_ready;
  logic [511:0] block_out;
  logic         block_valid, block_ready, block_last, frame_done;

  always #5 clk = ~clk;

  dct_block_assembler #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .block_out(block_out),
    .block_valid(block_valid), .block_ready(block_ready),
    .block_last(block_last), .frame_done(frame_done)
  );

  typedef struct {logic [511:0] d; bit last;} blk_t;
  blk_t         sbq[$];
  logic [511:0] seen[$];
  int n_chk = 0, n_pass = 0, fd_cnt = 0;
  bit rnd_rdy = 0;

  // Reference model: the frame as the spec describes it
  byte unsigned strip_m [8][W];
  int m_n = 0, m_s = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_blk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_accept(input byte unsigned d, input bit sof);
    blk_t x;
    if (sof) begin m_n = 0; m_s = 0; end
    strip_m[m_n / W][m_n % W] = d;
    m_n++;
    if (m_n == 8 * W) begin
      for (int b = 0; b < NB; b++) begin
        for (int i = 0; i < 64; i++) x.d[i*8 +: 8] = strip_m[i / 8][b * 8 + i % 8];
        x.last = (m_s == NS - 1) && (b == NB - 1);
        sbq.push_back(x);
      end
      m_s = (m_s + 1) % NS;
      m_n = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rnd_rdy) block_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer one pixel (called at a negedge) until accepted, then retire it
  task automatic send(input byte unsigned d, input bit sof, input int gap);
    int t = 0;
    repeat (gap) tick();
    pix_data = d; pix_sof = sof; pix_valid = 1'b1;
    while (!pix_ready && t < 3000) begin tick(); t++; end
    if (!pix_ready) begin
      chk("pix_ready_timeout", 0, 1);
      pix_valid = 1'b0; pix_sof = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(d, sof);
    tick();
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic send_rand(input int n, input bit first_sof, input int maxgap);
    for (int p = 0; p < n; p++) send(8'($urandom), first_sof && p == 0, $urandom_range(0, maxgap));
  endtask

  task automatic drain();
    int t = 0;
    rnd_rdy = 1;
    while (sbq.size() != 0 && t < 2000) begin tick(); t++; end
    chk("drain_queue_empty", sbq.size(), 0);
    repeat (3) tick();
  endtask

  // Monitor: compare every handshake against the scoreboard head
  bit exp_fd = 0, prev_stall = 0, prev_last = 0;
  logic [511:0] prev_out;
  blk_t e;
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        exp_fd = 0; prev_stall = 0;
      end else begin
        if (frame_done || exp_fd) chk("frame_done", frame_done, exp_fd);
        if (frame_done) fd_cnt++;
        exp_fd = 0;
        if (prev_stall) begin
          chk("stall_valid", block_valid, 1);
          chk("stall_last", block_last, prev_last);
          chk_blk("stall_data", block_out, prev_out);
        end
        if (block_valid && block_ready) begin
          if (sbq.size() == 0) chk("unexpected_block", 1, 0);
          else begin
            e = sbq.pop_front();
            chk_blk("block_data", block_out, e.d);
            chk("block_last", block_last, e.last);
            seen.push_back(block_out);
            exp_fd = e.last;
          end
        end
        prev_stall = block_valid && !block_ready;
        prev_out   = block_out;
        prev_last  = block_last;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [511:0] b;
  int mark;
  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; block_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_block_valid", block_valid, 0);
    chk("rst_block_last", block_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_block_out_zero", block_out != '0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("pix_ready_after_rst", pix_ready, 1);

    // Ramp frame, block_ready held high
    block_ready = 1'b1;
    seen.delete(); fd_cnt = 0;
    for (int p = 0; p < 128; p++) send(8'(p), p == 0, 0);
`ifdef DCT_BLKASM_PINGPONG_EN
    chk("pp_ready_after_strip", pix_ready, 1);
`else
    chk("ready_low_after_strip", pix_ready, 0);
    tick();
    chk("ready_low_after_hs1", pix_ready, 0);
    tick();
    chk("ready_high_after_hs2", pix_ready, 1);
`endif
    for (int p = 128; p < 256; p++) send(8'(p), 0, 0);
    drain();
    chk("ramp_block_count", seen.size(), 4);
    b = seen[0];
    chk("b0_byte0", b[7:0], 0);
    chk("b0_byte1", b[15:8], 1);
    chk("b0_byte8", b[71:64], 16);
    chk("b0_byte63", b[511:504], 119);
    b = seen[1];
    chk("b1_byte0", b[7:0], 8);
    chk("b1_byte63", b[511:504], 127);
    b = seen[2];
    chk("strip1_byte0", b[7:0], 128);
    chk("ramp_frame_done_count", fd_cnt, 1);

    // Backpressure: hold block_ready low for 20 cycles after valid rises
    rnd_rdy = 0; block_ready = 1'b0;
    send_rand(128, 0, 0);
    for (int t = 0; t < 100 && !block_valid; t++) tick();
    chk("bp_valid_rose", block_valid, 1);
    b = block_out;
    repeat (20) tick();
    chk("bp_valid_held", block_valid, 1);
    chk_blk("bp_data_held", block_out, b);
    rnd_rdy = 1;
    send_rand(128, 0, 2);
    drain();

    // Ready behaviour with both strips waiting on the reader
    rnd_rdy = 0; block_ready = 1'b0;
`ifdef DCT_BLKASM_PINGPONG_EN
    send_rand(256, 1, 0);
    chk("pp_ready_low_both_full", pix_ready, 0);
    block_ready = 1'b1;
    tick();
    chk("pp_ready_low_after_hs1", pix_ready, 0);
    tick();
    chk("pp_ready_high_after_hs2", pix_ready, 1);
    drain();
`else
    send_rand(128, 1, 0);
    chk("stall_ready_low", pix_ready, 0);
    tick();
    chk("stall_ready_still_low", pix_ready, 0);
    rnd_rdy = 1;
    send_rand(128, 0, 1);
    drain();
`endif

    // SOF mid-strip discards the partial strip
    rnd_rdy = 1;
    send_rand(40, 1, 1);
    chk("sof_no_partial_blocks", sbq.size(), 0);
    mark = seen.size();
    send(8'hAA, 1, 0);
    send_rand(127, 0, 1);
    drain();
    chk("sof_blocks_emitted", seen.size(), mark + NB);
    b = seen[mark];
    chk("sof_byte0", b[7:0], 8'hAA);
    send_rand(128, 0, 1);
    drain();

    // Reset while the final block of the frame is stalled
    rnd_rdy = 1;
    send_rand(128, 1, 0);
    drain();
    rnd_rdy = 0; block_ready = 1'b0;
    send_rand(128, 0, 0);
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
    chk("pre_rst_valid", block_valid, 1);
    chk("pre_rst_last", block_last, 1);
    rst = 1'b1;
    tick();
    chk("midrst_block_valid", block_valid, 0);
    chk("midrst_block_last", block_last, 0);
    chk("midrst_pix_ready", pix_ready, 0);
    chk("midrst_frame_done", frame_done, 0);
    sbq.delete(); m_n = 0; m_s = 0;
    rst = 1'b0;
    tick();
    chk("post_rst_pix_ready", pix_ready, 1);
    chk("post_rst_block_valid", block_valid, 0);

    // Full frame after reset
    fd_cnt = 0;
    rnd_rdy = 1;
    send_rand(256, 1, 1);
    drain();
    chk("post_rst_frame_done", fd_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
